// File: rtl/gate_access_ctrl_param_pkg.sv
// ---------------------------------------------------------------------------
// gate_access_ctrl_param_pkg
// Shared definitions for the parking-gate access controller.
//   gate_state_e : controller states. The encodings are fixed because the
//                  stimulus benches decode them directly.
//   gate_outs_t  : registered gate/alarm output bundle.
//   outs_for()   : output decode for a given state.
// ---------------------------------------------------------------------------
package gate_access_ctrl_param_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ESPERA_PIN = 2'd1,
    ABIERTO    = 2'd2,
    BLOQUEO    = 2'd3
  } gate_state_e;

  typedef struct packed {
    logic cerrado;
    logic abierto;
    logic alarma;
    logic bloqueo;
  } gate_outs_t;

  // Cerrado and Abierto are always complementary. Alarma tracks Bloqueo.
  function automatic gate_outs_t outs_for(input gate_state_e s);
    gate_outs_t o;
    o.abierto = (s == ABIERTO);
    o.cerrado = (s != ABIERTO);
    o.bloqueo = (s == BLOQUEO);
    o.alarma  = (s == BLOQUEO);
    return o;
  endfunction

endpackage

// File: rtl/gate_access_ctrl_param_pin_strobe_det.sv
// ---------------------------------------------------------------------------
// pin_strobe_det
// Turns a keypad level into a single-cycle strobe per key press.
// The strobe fires when Pin leaves the idle value. Holding a key produces
// exactly one strobe.
// Ports:
//   Clk      in   rising-edge clock
//   Reset    in   synchronous, active-low reset
//   Pin      in   keypad value (PIN_ESPERA when no key is pressed)
//   pin_stb  out  high for the cycle in which a new key press is seen
// ---------------------------------------------------------------------------
module pin_strobe_det #(
  parameter int                PIN_W      = 8,
  parameter logic [PIN_W-1:0]  PIN_ESPERA = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [PIN_W-1:0] Pin,
  output logic             pin_stb
);

  logic [PIN_W-1:0] pin_prev;

  // Starting from the idle value means a key already held when reset is
  // released still yields one strobe.
  always_ff @(posedge Clk) begin
    // NOTE: state is written with <= so every register samples pre-edge values.
    if (!Reset) pin_prev <= PIN_ESPERA;
    else        pin_prev <= Pin;
  end

  assign pin_stb = (Pin != PIN_ESPERA) && (pin_prev == PIN_ESPERA);

endmodule

// File: rtl/gate_access_ctrl_param.sv
// ---------------------------------------------------------------------------
// gate_access_ctrl_param
// Parking-gate access controller. A vehicle arrival arms PIN entry. A correct
// PIN opens the gate. MAX_INTENTOS consecutive wrong PINs lock the gate and
// raise the alarm. PIN entry is abandoned after TIMEOUT_CIC idle cycles.
// Passing while a second vehicle sits on the entry sensor (tailgating) also
// locks the gate.
// Ports:
//   Clk       in   rising-edge clock
//   Reset     in   synchronous, active-low reset
//   Vehiculo  in   vehicle present at entry sensor
//   Termino   in   vehicle finished passing (exit sensor)
//   Pin       in   keypad value, PIN_ESPERA when idle
//   Cerrado   out  gate closed
//   Abierto   out  gate open
//   Alarma    out  alarm active
//   Bloqueo   out  controller locked out
//   Intentos  out  consecutive wrong PINs since the last correct PIN
// ---------------------------------------------------------------------------
module gate_access_ctrl_param
  import gate_access_ctrl_param_pkg::*;
#(
  parameter int                PIN_W        = 8,
  parameter logic [PIN_W-1:0]  PIN_CORRECTO = 'h08,
  parameter logic [PIN_W-1:0]  PIN_ESPERA   = '0,
  parameter int                MAX_INTENTOS = 3,
  parameter int                TIMEOUT_CIC  = 16,
  parameter int                CNT_W        = $clog2(MAX_INTENTOS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic [PIN_W-1:0] Pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [CNT_W-1:0] Intentos
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CIC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CIC - 1);
  localparam logic [CNT_W-1:0] INT_MAX  = CNT_W'(MAX_INTENTOS);

  gate_state_e      state;
  gate_outs_t       outs;
  logic [TMR_W-1:0] timer;
  logic             pin_stb;
  logic             pin_ok;

  pin_strobe_det #(
    .PIN_W      (PIN_W),
    .PIN_ESPERA (PIN_ESPERA)
  ) u_pin_strobe (
    .Clk     (Clk),
    .Reset   (Reset),
    .Pin     (Pin),
    .pin_stb (pin_stb)
  );

  assign pin_ok = (Pin == PIN_CORRECTO);

  // Outputs are loaded together with the state they decode, so they change
  // on the same edge as the state.
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous and overrides every transition below; all
    // registers here are plain flops, so every one of them is reset.
    if (!Reset) begin
      state    <= IDLE;
      outs     <= outs_for(IDLE);
      timer    <= '0;
      Intentos <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Vehiculo) begin
            state <= ESPERA_PIN;
            outs  <= outs_for(ESPERA_PIN);
            timer <= '0;
          end
        end

        ESPERA_PIN: begin
          timer <= timer + 1'b1;
          if (!Vehiculo) begin
            state <= IDLE;
            outs  <= outs_for(IDLE);
          end else if (pin_stb && pin_ok) begin
            state    <= ABIERTO;
            outs     <= outs_for(ABIERTO);
            Intentos <= '0;
          end else if (pin_stb && (Intentos >= INT_MAX - 1'b1)) begin
            state    <= BLOQUEO;
            outs     <= outs_for(BLOQUEO);
            Intentos <= INT_MAX;
          end else if (pin_stb) begin
            // A wrong PIN restarts the entry window.
            Intentos <= Intentos + 1'b1;
            timer    <= '0;
          end else if (timer == TMR_LAST) begin
            state <= IDLE;
            outs  <= outs_for(IDLE);
          end
        end

        ABIERTO: begin
          if (Termino && Vehiculo) begin
            state <= BLOQUEO;
            outs  <= outs_for(BLOQUEO);
          end else if (Termino) begin
            state <= IDLE;
            outs  <= outs_for(IDLE);
          end
        end

        BLOQUEO: begin
          // Only the correct PIN leaves lockout; Intentos stays saturated.
          if (pin_stb && pin_ok) begin
            state    <= IDLE;
            outs     <= outs_for(IDLE);
            Intentos <= '0;
          end
        end

        default: begin
          state <= IDLE;
          outs  <= outs_for(IDLE);
        end
      endcase
    end
  end

  assign Cerrado = outs.cerrado;
  assign Abierto = outs.abierto;
  assign Alarma  = outs.alarma;
  assign Bloqueo = outs.bloqueo;

endmodule
